bht_update_ctrl: RTL and testbench

BHT_UPDATE_CTRL -- requirements
Module: bht_update_ctrl

---
 rtl/bht_pkg.sv | 31 +++
 rtl/bht_state_next.sv | 13 +
 rtl/bht_update_ctrl.sv | 123 ++++++++++++
 tb/tb_bht_update_ctrl.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/bht_pkg.sv
// Shared definitions for the branch-history-table update path:
// predictor state encodings, queue depth and the state transition rule.
package bht_pkg;

  localparam int FIFO_DEPTH = 4;

  localparam logic [1:0] ST_00 = 2'b00;
  localparam logic [1:0] ST_01 = 2'b01;
  localparam logic [1:0] ST_10 = 2'b10;
  localparam logic [1:0] ST_11 = 2'b11;

  function automatic logic [1:0] next_state(
    input logic [1:0] old,
    input logic       taken
  );
    logic [1:0] ns;
    case ({old, taken})
      3'b000:  ns = ST_01;
      3'b001:  ns = ST_10;
      3'b010:  ns = ST_01;
      3'b011:  ns = ST_00;
      3'b100:  ns = ST_11;
      3'b101:  ns = ST_10;
      3'b110:  ns = ST_01;
      3'b111:  ns = ST_10;
      default: ns = ST_00;
    endcase
    return ns;
  endfunction

endpackage

// File: rtl/bht_state_next.sv
// Combinational predictor-state successor for one pending update;
// one copy per forwarding source.
module bht_state_next
  import bht_pkg::*;
(
  input  logic [1:0] state_old,
  input  logic       taken,
  output logic [1:0] state_new
);

  assign state_new = next_state(state_old, taken);

endmodule

// File: rtl/bht_update_ctrl.sv
// Queues resolved-branch updates and issues them one per cycle to the
// table's single update port, forwarding state between same-PC updates.
module bht_update_ctrl
  import bht_pkg::*;
#(
  parameter int IM_ADDR_BIT = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [IM_ADDR_BIT-1:0] req_pc_4,
  input  logic [IM_ADDR_BIT-1:0] req_pc_remote,
  input  logic [1:0]             req_state_old,
  input  logic                   req_taken,
  output logic                   req_ready,
  input  logic                   hold,
  input  logic                   clear,
  output logic                   upd_en,
  output logic [IM_ADDR_BIT-1:0] upd_pc_4,
  output logic [IM_ADDR_BIT-1:0] upd_pc_remote,
  output logic [1:0]             upd_state_old,
  output logic                   upd_taken,
  output logic [2:0]             pending
);

  logic [IM_ADDR_BIT-1:0] pc4_q [FIFO_DEPTH];
  logic [IM_ADDR_BIT-1:0] rem_q [FIFO_DEPTH];
  logic [1:0]             st_q  [FIFO_DEPTH];
  logic                   tk_q  [FIFO_DEPTH];

  logic [1:0] rd_ptr;
  logic [1:0] wr_ptr;
  logic [2:0] cnt_q;

  logic       enq;
  logic       deq;
  logic [1:0] fwd_st;
  logic [1:0] idx;

  logic [1:0] fifo_nxt [FIFO_DEPTH];
  logic [1:0] out_nxt;

  assign req_ready = (cnt_q < 3'(FIFO_DEPTH));
  assign pending   = cnt_q;
  assign enq       = req_valid && req_ready && !clear;
  assign deq       = (cnt_q != 3'd0) && !hold && !clear;

  for (genvar g = 0; g < FIFO_DEPTH; g++) begin : g_fwd
    bht_state_next u_nxt (
      .state_old (st_q[g]),
      .taken     (tk_q[g]),
      .state_new (fifo_nxt[g])
    );
  end

  bht_state_next u_out_nxt (
    .state_old (upd_state_old),
    .taken     (upd_taken),
    .state_new (out_nxt)
  );

  // Scan oldest to youngest so the youngest match wins; the output
  // register is older than anything still queued.
  always_comb begin
    fwd_st = req_state_old;
    idx    = rd_ptr;
    if (upd_en && (upd_pc_4 == req_pc_4))
      fwd_st = out_nxt;
    for (int i = 0; i < FIFO_DEPTH; i++) begin
      idx = rd_ptr + 2'(i);
      if ((3'(i) < cnt_q) && (pc4_q[idx] == req_pc_4))
        fwd_st = fifo_nxt[idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc4_q[i] <= '0;
        rem_q[i] <= '0;
        st_q[i]  <= ST_00;
        tk_q[i]  <= 1'b0;
      end
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (enq) begin
        pc4_q[wr_ptr] <= req_pc_4;
        rem_q[wr_ptr] <= req_pc_remote;
        st_q[wr_ptr]  <= fwd_st;
        tk_q[wr_ptr]  <= req_taken;
        wr_ptr        <= wr_ptr + 2'd1;
      end
      if (deq)
        rd_ptr <= rd_ptr + 2'd1;
      cnt_q <= cnt_q + 3'(enq) - 3'(deq);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      upd_en        <= 1'b0;
      upd_pc_4      <= '0;
      upd_pc_remote <= '0;
      upd_state_old <= ST_00;
      upd_taken     <= 1'b0;
    end else begin
      upd_en <= deq;
      if (deq) begin
        upd_pc_4      <= pc4_q[rd_ptr];
        upd_pc_remote <= rem_q[rd_ptr];
        upd_state_old <= st_q[rd_ptr];
        upd_taken     <= tk_q[rd_ptr];
      end
    end
  end

endmodule

// File: tb/tb_bht_update_ctrl.sv
// Self-checking bench for bht_update_ctrl: directed scenarios then
// random traffic, compared against a queue-based reference model.
module tb_bht_update_ctrl;

  typedef struct {
    logic [31:0] pc4;
    logic [31:0] rem;
    logic [1:0]  st;
    logic        tk;
  } ent_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic [31:0] req_pc_4 = '0;
  logic [31:0] req_pc_remote = '0;
  logic [1:0]  req_state_old = '0;
  logic        req_taken = 1'b0;
  logic        req_ready;
  logic        hold = 1'b0;
  logic        clear = 1'b0;
  logic        upd_en;
  logic [31:0] upd_pc_4;
  logic [31:0] upd_pc_remote;
  logic [1:0]  upd_state_old;
  logic        upd_taken;
  logic [2:0]  pending;

  int total = 0;
  int bad = 0;

  ent_t q[$];
  ent_t m_out;
  logic m_en;

  // Successor table indexed by {old, taken}
  logic [1:0] nxt_tbl [8] = '{2'b01, 2'b10, 2'b01, 2'b00,
                              2'b11, 2'b10, 2'b01, 2'b10};

  bht_update_ctrl #(.IM_ADDR_BIT(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_pc_4      (req_pc_4),
    .req_pc_remote (req_pc_remote),
    .req_state_old (req_state_old),
    .req_taken     (req_taken),
    .req_ready     (req_ready),
    .hold          (hold),
    .clear         (clear),
    .upd_en        (upd_en),
    .upd_pc_4      (upd_pc_4),
    .upd_pc_remote (upd_pc_remote),
    .upd_state_old (upd_state_old),
    .upd_taken     (upd_taken),
    .pending       (pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_outputs();
    chk("upd_en", 32'(upd_en), 32'(m_en));
    chk("upd_pc_4", upd_pc_4, m_out.pc4);
    chk("upd_pc_remote", upd_pc_remote, m_out.rem);
    chk("upd_state_old", 32'(upd_state_old), 32'(m_out.st));
    chk("upd_taken", 32'(upd_taken), 32'(m_out.tk));
    chk("pending", 32'(pending), 32'(q.size()));
  endtask

  function automatic logic [1:0] fwd_state(input logic [31:0] pc,
                                           input logic [1:0] old);
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].pc4 == pc)
        return nxt_tbl[{q[i].st, q[i].tk}];
    if (m_en && m_out.pc4 == pc)
      return nxt_tbl[{m_out.st, m_out.tk}];
    return old;
  endfunction

  task automatic model_reset();
    q.delete();
    m_en = 1'b0;
    m_out = '{pc4: '0, rem: '0, st: 2'b00, tk: 1'b0};
  endtask

  // Starts and ends 1 time unit after a rising edge.
  task automatic cyc(input logic v, input logic [31:0] pc4,
                     input logic [31:0] rem, input logic [1:0] st,
                     input logic tk, input logic h, input logic c);
    logic acc;
    logic dq;
    ent_t e;
    req_valid = v;
    req_pc_4 = pc4;
    req_pc_remote = rem;
    req_state_old = st;
    req_taken = tk;
    hold = h;
    clear = c;
    #1;
    chk("req_ready", 32'(req_ready), 32'(q.size() < 4));
    acc = v && (q.size() < 4) && !c;
    dq = (q.size() > 0) && !h && !c;
    e = '{pc4: pc4, rem: rem, st: fwd_state(pc4, st), tk: tk};
    if (dq) begin
      m_out = q.pop_front();
      m_en = 1'b1;
    end else begin
      m_en = 1'b0;
    end
    if (c) q.delete();
    if (acc) q.push_back(e);
    @(posedge clk);
    #1;
    chk_outputs();
  endtask

  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++)
      cyc(1'b0, 32'h0, 32'h0, 2'b00, 1'b0, h, 1'b0);
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    model_reset();
    chk("rst_upd_en", 32'(upd_en), 32'h0);
    chk("rst_pc_4", upd_pc_4, 32'h0);
    chk("rst_pc_remote", upd_pc_remote, 32'h0);
    chk("rst_state_old", 32'(upd_state_old), 32'h0);
    chk("rst_taken", 32'(upd_taken), 32'h0);
    chk("rst_pending", 32'(pending), 32'h0);
    chk("rst_ready", 32'(req_ready), 32'h1);
    req_valid = 1'b0;
    hold = 1'b0;
    clear = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] pcs [4];
    pcs[0] = 32'h10; pcs[1] = 32'h14; pcs[2] = 32'h20; pcs[3] = 32'h24;
    model_reset();

    #2;
    apply_reset();

    // single request, issues two edges later
    cyc(1'b1, 32'h10, 32'h40, 2'b10, 1'b1, 1'b0, 1'b0);
    chk("single_not_yet", 32'(upd_en), 32'h0);
    idle(1, 1'b0);
    chk("single_issue_pc", upd_pc_4, 32'h10);
    chk("single_issue_st", 32'(upd_state_old), 32'h2);
    idle(2, 1'b0);

    // five requests under hold, then drain
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 32'h100 + 32'(4 * i), 32'h200 + 32'(i), 2'(i),
          1'(i), 1'b1, 1'b0);
    chk("full_pending", 32'(pending), 32'h4);
    chk("full_ready", 32'(req_ready), 32'h0);
    idle(2, 1'b1);
    for (int i = 0; i < 4; i++) begin
      idle(1, 1'b0);
      chk("drain_order", upd_pc_4, 32'h100 + 32'(4 * i));
    end
    idle(2, 1'b0);

    // same-pc forwarding
    cyc(1'b1, 32'h20, 32'h80, 2'b00, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h20, 32'h80, 2'b00, 1'b1, 1'b1, 1'b0);
    idle(1, 1'b0);
    idle(1, 1'b0);
    chk("fwd_state", 32'(upd_state_old), 32'h1);
    idle(2, 1'b0);

    // clear with concurrent request
    for (int i = 0; i < 3; i++)
      cyc(1'b1, 32'h300 + 32'(4 * i), 32'h0, 2'b01, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 32'h400, 32'h0, 2'b01, 1'b0, 1'b0, 1'b1);
    chk("clear_pending", 32'(pending), 32'h0);
    idle(3, 1'b0);

    // reset mid-operation with two pending
    cyc(1'b1, 32'h500, 32'h1, 2'b11, 1'b1, 1'b1, 1'b0);
    cyc(1'b1, 32'h504, 32'h2, 2'b11, 1'b0, 1'b1, 1'b0);
    apply_reset();
    idle(3, 1'b0);

    // full queue with continuous traffic and no hold
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 32'h600 + 32'(4 * i), 32'h0, 2'b10, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 8; i++)
      cyc(1'b1, 32'h700 + 32'(4 * i), 32'h9, 2'b00, 1'(i), 1'b0, 1'b0);
    idle(6, 1'b0);

    // random traffic with a small PC pool to exercise forwarding
    for (int i = 0; i < 400; i++)
      cyc(1'($urandom_range(0, 3) != 0), pcs[$urandom_range(0, 3)],
          $urandom, 2'($urandom), 1'($urandom),
          1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0));
    idle(6, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
